// File: rtl/mult16_seq_ctrl.sv
// Sequential 16x16 unsigned shift-and-add multiplier.
// Drives the external 16-step counter and stops iterating when that counter reports done.
module mult16_seq_ctrl #(
    parameter int WIDTH = 16  // fixed by the external counter's terminal count
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic [2*WIDTH-1:0]   product,
    output logic                 product_valid,
    output logic                 count16set,
    output logic                 count16reset,
    input  logic                 count16done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_ITER = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] m;
    logic [WIDTH:0]   sum;

    // sum[WIDTH] is the carry, which lands in the top accumulator bit after the shift
    assign sum = {1'b0, acc} + (q[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            acc     <= '0;
            q       <= '0;
            m       <= '0;
            product <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        m     <= multiplicand;
                        q     <= multiplier;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    acc   <= '0;
                    state <= S_ITER;
                end
                S_ITER: begin
                    {acc, q} <= {sum, q[WIDTH-1:1]};
                    // Capture on the final step so product is already valid in DONE
                    if (count16done) begin
                        product <= {sum, q[WIDTH-1:1]};
                        state   <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy          = (state != S_IDLE);
    assign product_valid = (state == S_DONE);
    assign count16set    = (state == S_ITER);
    assign count16reset  = (state == S_LOAD);

endmodule
